debounce_multi_fsmd: RTL and testbench
======================================

DEBOUNCE_MULTI_FSMD -- requirements
Module: debounce_multi_fsmd

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter CH, default 4: number of independent button channels (1..32).
REQ-003 Parameter N, default 21: debounce counter width; stability window is 2^N clock cycles.
REQ-004 Parameter L, default 27: long-press counter width; long-press threshold is 2^L-1 cycles held in ONE.
REQ-005 i_CLK  in  1  system clock, rising edge.
REQ-006 i_RST_N  in  1  asynchronous active-low reset.
REQ-007 i_BTN  in  CH  raw asynchronous button inputs, bit k = channel k.
REQ-008 o_DB_LVL  out  CH  debounced level per channel.
REQ-009 o_PRESS_TICK  out  CH  one-cycle pulse on a debounced press.
REQ-010 o_RELEASE_TICK  out  CH  one-cycle pulse on a debounced release.
REQ-011 o_LONG_TICK  out  CH  one-cycle pulse when a press reaches the long-press threshold.
REQ-012 o_LONG_LVL  out  CH  high from the long-press tick until the debounced release.

Function
REQ-013 Each channel SHALL pass i_BTN[k] through a two-flop synchronizer; all FSM decisions SHALL use only the synchronized bit s[k].
REQ-014 Each channel SHALL have its own FSM, N-bit down counter q, L-bit up counter h and long flag; channels SHALL NOT interact.
REQ-015 States: ZERO, WAIT1, ONE, WAIT0.
REQ-016 ZERO: s=1 -> WAIT1, q loaded with all ones; otherwise stay.
REQ-017 WAIT1: s=0 -> ZERO immediately (glitch abort, no tick); s=1 and q!=0 -> q decrements; s=1 and q==0 -> ONE.
REQ-018 ONE: s=0 -> WAIT0, q loaded with all ones; s=1 -> h increments, saturating at all ones.
REQ-019 WAIT0: s=1 -> ONE immediately (no tick, h and long flag retained); s=0 and q!=0 -> q decrements; s=0 and q==0 -> ZERO.
REQ-020 Illegal state encodings SHALL recover to ZERO on the next edge.
REQ-021 o_DB_LVL[k] SHALL be high exactly while the state is ONE or WAIT0.
REQ-022 o_PRESS_TICK[k] SHALL be registered and high for exactly the first cycle after a WAIT1->ONE transition; WAIT0->ONE SHALL NOT pulse it.
REQ-023 o_RELEASE_TICK[k] SHALL be registered and high for exactly the first cycle after a WAIT0->ZERO transition.
REQ-024 h SHALL be cleared on WAIT1->ONE; when h reaches all ones and the long flag is clear, o_LONG_TICK[k] SHALL pulse for one cycle and the long flag SHALL set.
REQ-025 o_LONG_LVL[k] SHALL equal the long flag, which clears on WAIT0->ZERO; at most one long tick SHALL occur per debounced press.
REQ-026 Latency: a clean rising i_BTN held stable SHALL raise o_DB_LVL and o_PRESS_TICK 2^N+2 rising edges after the first edge that samples i_BTN=1; release latency SHALL be symmetric.
REQ-027 Counter arithmetic SHALL be modulo-free: q never decrements below 0, h never wraps.

Reset
REQ-028 Assertion of i_RST_N=0 SHALL asynchronously force all states to ZERO, q, h, synchronizer flops and long flags to 0, and every output to 0.
REQ-029 Reset asserted mid-operation (any state, any counter value) SHALL produce the same result with no tick on or after deassertion unless a new full debounce completes.
REQ-030 After deassertion, a channel with i_BTN held high SHALL complete a normal debounce and issue one press tick.

Verification (CH=4, N=3, L=5)
REQ-031 Clean press ch0: i_BTN=0001 held -> o_DB_LVL[0] and o_PRESS_TICK[0] rise 10 edges after first sampling edge; tick width 1 cycle; other channels stay 0.
REQ-032 Glitch: i_BTN[1] high for 5 cycles then low -> no o_DB_LVL[1], no ticks; FSM back in ZERO.
REQ-033 Release bounce: ch2 in ONE, i_BTN[2] low 4 cycles, high, then low stable -> one o_RELEASE_TICK[2] only after the final 10-edge window; no extra press tick.
REQ-034 Long press: ch3 held -> o_LONG_TICK[3] exactly once 31 cycles after entering ONE, o_LONG_LVL[3] high until release tick cycle then 0.
REQ-035 Simultaneous: i_BTN=1111 same edge -> all four press ticks on the same cycle.
REQ-036 Reset mid-WAIT1 on ch0 and during ONE on ch1 -> all outputs 0 immediately; no tick after deassertion with buttons low.

Source files
------------

// File: rtl/debounce_multi_fsmd.sv
// Multi-channel button debouncer.
// Each channel synchronizes its raw input, then runs a four-state debounce FSM
// with a stability down-counter, a hold-time up-counter and a long-press flag.
//
// state | meaning
// ZERO  | debounced low, waiting for the input to go high
// WAIT1 | input high, counting down the stability window before declaring a press
// ONE   | debounced high, counting hold time toward the long-press threshold
// WAIT0 | input low, counting down the stability window before declaring a release
module debounce_multi_fsmd #(
    parameter int CH = 4,
    parameter int N  = 21,
    parameter int L  = 27
) (
    input  logic          i_CLK,
    input  logic          i_RST_N,
    input  logic [CH-1:0] i_BTN,
    output logic [CH-1:0] o_DB_LVL,
    output logic [CH-1:0] o_PRESS_TICK,
    output logic [CH-1:0] o_RELEASE_TICK,
    output logic [CH-1:0] o_LONG_TICK,
    output logic [CH-1:0] o_LONG_LVL
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [L-1:0] H_MAX = '1;

    logic [CH-1:0] sync_a;
    logic [CH-1:0] sync_b;

    // Two-flop synchronizer for all raw button inputs.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= i_BTN;
            sync_b <= sync_a;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        state_t       state;
        state_t       state_nxt;
        logic [N-1:0] q;
        logic [N-1:0] q_nxt;
        logic [L-1:0] h;
        logic [L-1:0] h_nxt;
        logic         long_flag;
        logic         long_nxt;
        logic         press_nxt;
        logic         release_nxt;
        logic         long_tick_nxt;
        logic         press_q;
        logic         release_q;
        logic         long_tick_q;
        logic         s;

        assign s = sync_b[k];

        // Per-channel state, counters, long flag and registered tick outputs.
        always_ff @(posedge i_CLK or negedge i_RST_N) begin
            if (!i_RST_N) begin
                state       <= ZERO;
                q           <= '0;
                h           <= '0;
                long_flag   <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                long_tick_q <= 1'b0;
            end else begin
                state       <= state_nxt;
                q           <= q_nxt;
                h           <= h_nxt;
                long_flag   <= long_nxt;
                press_q     <= press_nxt;
                release_q   <= release_nxt;
                long_tick_q <= long_tick_nxt;
            end
        end

        // Next-state, counter updates and tick requests for one channel.
        always_comb begin
            state_nxt     = state;
            q_nxt         = q;
            h_nxt         = h;
            long_nxt      = long_flag;
            press_nxt     = 1'b0;
            release_nxt   = 1'b0;
            long_tick_nxt = 1'b0;
            case (state)
                ZERO: begin
                    if (s) begin
                        state_nxt = WAIT1;
                        q_nxt     = '1;
                    end
                end
                WAIT1: begin
                    if (!s) begin
                        state_nxt = ZERO;
                    end else if (q != '0) begin
                        q_nxt = q - N'(1);
                    end else begin
                        state_nxt = ONE;
                        h_nxt     = '0;
                        press_nxt = 1'b1;
                    end
                end
                ONE: begin
                    if (!s) begin
                        state_nxt = WAIT0;
                        q_nxt     = '1;
                    end else if (h != H_MAX) begin
                        h_nxt = h + L'(1);
                        // The tick fires on the edge where h lands on all ones.
                        if ((h == H_MAX - L'(1)) && !long_flag) begin
                            long_nxt      = 1'b1;
                            long_tick_nxt = 1'b1;
                        end
                    end
                end
                WAIT0: begin
                    if (s) begin
                        state_nxt = ONE;
                    end else if (q != '0) begin
                        q_nxt = q - N'(1);
                    end else begin
                        state_nxt   = ZERO;
                        release_nxt = 1'b1;
                        long_nxt    = 1'b0;
                    end
                end
                default: state_nxt = ZERO;
            endcase
        end

        assign o_DB_LVL[k]       = (state == ONE) || (state == WAIT0);
        assign o_PRESS_TICK[k]   = press_q;
        assign o_RELEASE_TICK[k] = release_q;
        assign o_LONG_TICK[k]    = long_tick_q;
        assign o_LONG_LVL[k]     = long_flag;
    end

endmodule

// File: tb/tb_debounce_multi_fsmd.sv
// Testbench for debounce_multi_fsmd: directed scenarios plus random button
// activity, every cycle compared against a run-length reference model.
module tb_debounce_multi_fsmd;
    localparam int CH   = 4;
    localparam int N    = 3;
    localparam int L    = 5;
    localparam int WIN  = 1 << N;
    localparam int HMAX = (1 << L) - 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] btn   = '0;
    logic [CH-1:0] db_lvl, press_tick, release_tick, long_tick, long_lvl;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: a debounced level flips once the synchronized input has
    // disagreed with it for WIN+1 consecutive edges; hold time counts edges
    // spent high with no pending disagreement.
    logic [CH-1:0] m_sync1, m_sync2, m_lvl, m_long;
    logic [CH-1:0] e_press, e_rel, e_lt;
    int            m_run  [CH];
    int            m_hold [CH];

    debounce_multi_fsmd #(.CH(CH), .N(N), .L(L)) dut (
        .i_CLK          (clk),
        .i_RST_N        (rst_n),
        .i_BTN          (btn),
        .o_DB_LVL       (db_lvl),
        .o_PRESS_TICK   (press_tick),
        .o_RELEASE_TICK (release_tick),
        .o_LONG_TICK    (long_tick),
        .o_LONG_LVL     (long_lvl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sync1 = '0; m_sync2 = '0; m_lvl = '0; m_long = '0;
        e_press = '0; e_rel = '0; e_lt = '0;
        for (int k = 0; k < CH; k++) begin
            m_run[k]  = 0;
            m_hold[k] = 0;
        end
    endtask

    task automatic model_edge();
        logic s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_press = '0; e_rel = '0; e_lt = '0;
        for (int k = 0; k < CH; k++) begin
            s = m_sync2[k];
            if (s != m_lvl[k]) begin
                m_run[k]++;
                if (m_run[k] == WIN + 1) begin
                    m_lvl[k] = s;
                    m_run[k] = 0;
                    if (s) begin
                        e_press[k] = 1'b1;
                        m_hold[k]  = 0;
                    end else begin
                        e_rel[k]  = 1'b1;
                        m_long[k] = 1'b0;
                    end
                end
            end else begin
                if (m_lvl[k] && m_run[k] == 0 && m_hold[k] < HMAX) begin
                    m_hold[k]++;
                    if (m_hold[k] == HMAX && !m_long[k]) begin
                        m_long[k] = 1'b1;
                        e_lt[k]   = 1'b1;
                    end
                end
                m_run[k] = 0;
            end
        end
        m_sync2 = m_sync1;
        m_sync1 = btn;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check($sformatf("outputs@%0d", cyc),
              32'({db_lvl, press_tick, release_tick, long_tick, long_lvl}),
              32'({m_lvl, e_press, e_rel, e_lt, m_long}));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Steps until the chosen tick (0 press, 1 release, 2 long) appears on
    // channel k; n is the number of edges taken, equal to budget on timeout.
    task automatic wait_tick(input int which, input int k, input int budget, output int n);
        logic hit;
        n = 0;
        while (n < budget) begin
            hit = (which == 0) ? press_tick[k] : (which == 1) ? release_tick[k] : long_tick[k];
            if (hit) break;
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int cnt;
        int seg [CH];
        model_reset();

        // Reset state.
        run(3);
        check("reset_outputs", 32'({db_lvl, press_tick, release_tick, long_tick, long_lvl}), 32'h0);
        rst_n = 1'b1;
        run(2);

        // Clean press on channel 0.
        btn = 4'b0001;
        step();
        wait_tick(0, 0, 30, n);
        check("press_latency", n, 10);
        check("press_lvl0", db_lvl[0], 1'b1);
        check("press_others", 32'(press_tick[3:1]), 32'h0);
        step();
        check("press_width", press_tick[0], 1'b0);

        // Glitch on channel 1.
        btn[1] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            cnt += int'(db_lvl[1] | press_tick[1] | release_tick[1]);
        end
        btn[1] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            cnt += int'(db_lvl[1] | press_tick[1] | release_tick[1]);
        end
        check("glitch_quiet", cnt, 0);

        // Release bounce on channel 2.
        btn[2] = 1'b1;
        run(12);
        check("bounce_in_one", db_lvl[2], 1'b1);
        btn[2] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            cnt += int'(press_tick[2] | release_tick[2]);
        end
        btn[2] = 1'b1;
        step();
        cnt += int'(press_tick[2] | release_tick[2]);
        btn[2] = 1'b0;
        step();
        cnt += int'(press_tick[2] | release_tick[2]);
        check("bounce_no_tick", cnt, 0);
        wait_tick(1, 2, 30, n);
        check("release_latency", n, 10);

        // Long press on channel 3.
        btn[3] = 1'b1;
        wait_tick(0, 3, 30, n);
        check("long_press_seen", press_tick[3], 1'b1);
        wait_tick(2, 3, 60, n);
        check("long_latency", n, 31);
        check("long_lvl_set", long_lvl[3], 1'b1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cnt += int'(long_tick[3]);
        end
        check("long_once", cnt, 0);
        check("long_lvl_held", long_lvl[3], 1'b1);
        btn[3] = 1'b0;
        step();
        check("long_lvl_pre_rel", long_lvl[3], 1'b1);
        wait_tick(1, 3, 30, n);
        check("long_rel_latency", n, 10);
        check("long_lvl_cleared", long_lvl[3], 1'b0);

        // Simultaneous press on all channels.
        btn = '0;
        run(20);
        check("all_released", 32'(db_lvl), 32'h0);
        btn = 4'hF;
        step();
        wait_tick(0, 0, 30, n);
        check("simul_latency", n, 10);
        check("simul_ticks", 32'(press_tick), 32'hF);

        // Reset mid-operation: ch1 in ONE, ch0 in WAIT1.
        btn = '0;
        run(20);
        btn = 4'b0010;
        step();
        wait_tick(0, 1, 30, n);
        run(3);
        btn = 4'b0011;
        run(5);
        #2 rst_n = 1'b0;
        #1;
        check("midop_reset", 32'({db_lvl, press_tick, release_tick, long_tick, long_lvl}), 32'h0);
        model_reset();
        btn = '0;
        run(3);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            cnt += int'(|{db_lvl, press_tick, release_tick, long_tick, long_lvl});
        end
        check("post_reset_quiet", cnt, 0);

        // Button held through reset still debounces once.
        #2 rst_n = 1'b0;
        btn = 4'b0001;
        run(2);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            cnt += int'(press_tick[0]);
        end
        check("held_reset_press", cnt, 1);
        check("held_reset_lvl", db_lvl[0], 1'b1);

        // Random activity: mixed short bounces and long holds per channel.
        for (int k = 0; k < CH; k++) seg[k] = 0;
        for (int i = 0; i < 2500; i++) begin
            for (int k = 0; k < CH; k++) begin
                if (seg[k] == 0) begin
                    btn[k] = 1'($urandom_range(0, 1));
                    seg[k] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6))
                                                         : int'($urandom_range(10, 50));
                end
                seg[k]--;
            end
            if (i == 1200) rst_n = 1'b0;
            if (i == 1203) rst_n = 1'b1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
